run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- RESET_CYCLES, 2, cycles dut_start is held high before a run.
- TIMEOUT, 16'hFFFF, run cycle limit.
REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, clock; posedge used.
- start, in, 1, reset; synchronous, active-high.
- ld_valid, in, 1, preload write request.
- ld_ready, out, 1, preload write accepted this cycle.
- ld_addr, in, 8, data-memory address.
- ld_data, in, 8, data-memory byte.
- go, in, 1, run request; single-cycle pulse or level.
- dut_halt, in, 1, processor halt flag.
- dut_start, out, 1, processor init; holds the processor in init while high.
- mem_wr_en, out, 1, data-memory write strobe.
- mem_addr, out, 8, data-memory write address.
- mem_data, out, 8, data-memory write data.
- busy, out, 1, high in RESET_DUT and RUN.
- done, out, 1, run finished.
- timeout, out, 1, run ended by the cycle limit.
- cycle_count, out, 16, cycles spent in RUN.
REQ-003 One clock, CLK; reset is synchronous and active-high on start.

Function
REQ-004 FSM states: IDLE, RESET_DUT, RUN, DONE. All outputs are registered except ld_ready.
REQ-005 ld_ready = 1 in IDLE and DONE, 0 in RESET_DUT and RUN.
REQ-006 A load is accepted when ld_valid and ld_ready are both 1.
- Next cycle: mem_wr_en=1, mem_addr=ld_addr, mem_data=ld_data.
- Otherwise mem_wr_en=0.
- Back-to-back accepts give one write per cycle.
REQ-007 A load accepted in DONE clears done and timeout and moves to IDLE. cycle_count is retained.
REQ-008 IDLE: dut_start=1. go=1 with ld_valid=0 moves to RESET_DUT. When go and ld_valid are both 1, the load wins and go is dropped, not latched.
REQ-009 RESET_DUT:
- dut_start=1; internal counter loads 0 on entry.
- Moves to RUN after exactly RESET_CYCLES cycles in the state.
- On entry, clears done, timeout and cycle_count to 0.
REQ-010 RUN:
- dut_start=0.
- cycle_count increments by 1 every RUN cycle; saturates, never wraps.
- dut_halt is ignored in the first RUN cycle.
REQ-011 RUN exit on dut_halt=1, from the second RUN cycle on: next state DONE, done=1, timeout=0. cycle_count freezes at the value including the halting cycle.
REQ-012 RUN exit on the limit: when cycle_count reaches TIMEOUT with dut_halt=0, next state DONE, done=1, timeout=1.
REQ-013 dut_halt=1 in the same cycle the limit is reached: halt wins, timeout=0.
REQ-014 DONE:
- dut_start=0, so the processor holds its state.
- done stays 1 until the next go or an accepted load.
- go in DONE moves to RESET_DUT; a rerun needs no reload.
REQ-015 go is ignored in RESET_DUT and RUN. ld_valid is not accepted there (ld_ready=0).
REQ-016 Latency from go (IDLE) to the first RUN cycle is RESET_CYCLES+1 clocks.

Reset
REQ-017 start=1 forces, on the next edge:
- state=IDLE, dut_start=1, mem_wr_en=0, busy=0, done=0, timeout=0, cycle_count=0, internal counters 0.
REQ-018 Reset in any state, including mid-RUN or mid-load:
- aborts the run immediately;
- a load accepted in the reset cycle is discarded and no write is issued.
REQ-019 While start=1, ld_ready=0 and go is ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Preload: three back-to-back loads (addr 0x00/0x01/0x02, data 0xA5/0x5A/0xFF) -> mem_wr_en high 3 consecutive cycles, each one cycle after its accept, matching addr/data.
- Normal run: go in IDLE, RESET_CYCLES=2; dut_halt rises in RUN cycle 10 -> dut_start high 2 cycles then low; done=1, timeout=0, cycle_count=10.
- Timeout: TIMEOUT=16'd20, dut_halt held 0 -> done=1, timeout=1, cycle_count=20.
- Halt on the limit cycle: dut_halt=1 in RUN cycle 20 with TIMEOUT=20 -> timeout=0; dut_halt=1 in RUN cycle 1 only -> ignored, run continues.
- Collision: go and ld_valid both 1 in IDLE -> write issued, state stays IDLE; go in DONE -> rerun with cycle_count restarted from 0.
- Reset mid-RUN at cycle 5, and reset during a load accept -> all outputs at reset values next cycle; no mem_wr_en pulse.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller: preloads processor data memory, holds it in init, runs it until halt or cycle limit.
// Latency: go to first RUN cycle is RESET_CYCLES+1 clocks; load write issues one clock after accept.
// Backpressure: ld_ready is low while busy or in reset; go is ignored while busy.
module run_ctrl #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        go,
    input  logic        dut_halt,
    output logic        dut_start,
    output logic        mem_wr_en,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {IDLE, RESET_DUT, RUN, DONE} state_t;

    // Last value of the reset-hold counter; a zero setting still spends one cycle in RESET_DUT.
    localparam logic [15:0] RC_LAST = (RESET_CYCLES > 0) ? 16'(RESET_CYCLES - 1) : 16'd0;

    state_t      state, state_nxt;
    logic [15:0] rst_cnt, rst_cnt_nxt;
    logic [15:0] count_nxt, count_inc;
    logic        done_nxt, timeout_nxt;
    logic        accept;

    assign ld_ready = !start && (state == IDLE || state == DONE);
    assign accept   = ld_valid && ld_ready;

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        count_nxt   = cycle_count;
        done_nxt    = done;
        timeout_nxt = timeout;
        count_inc   = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
        case (state)
            IDLE: begin
                if (go && !accept) begin
                    state_nxt   = RESET_DUT;
                    rst_cnt_nxt = 16'd0;
                    count_nxt   = 16'd0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            RESET_DUT: begin
                if (rst_cnt >= RC_LAST) begin
                    state_nxt = RUN;
                end else begin
                    rst_cnt_nxt = rst_cnt + 16'd1;
                end
            end
            RUN: begin
                count_nxt = count_inc;
                // cycle_count==0 marks the first RUN cycle, where halt is not yet trusted
                if (dut_halt && cycle_count != 16'd0) begin
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b0;
                end else if (count_inc >= TIMEOUT) begin
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                end else if (go) begin
                    state_nxt   = RESET_DUT;
                    rst_cnt_nxt = 16'd0;
                    count_nxt   = 16'd0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            state       <= IDLE;
            rst_cnt     <= 16'd0;
            dut_start   <= 1'b1;
            mem_wr_en   <= 1'b0;
            mem_addr    <= 8'd0;
            mem_data    <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= 16'd0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            dut_start   <= (state_nxt == IDLE) || (state_nxt == RESET_DUT);
            busy        <= (state_nxt == RESET_DUT) || (state_nxt == RUN);
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            cycle_count <= count_nxt;
            mem_wr_en   <= accept;
            if (accept) begin
                mem_addr <= ld_addr;
                mem_data <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl with RESET_CYCLES=2, TIMEOUT=20.
module tb_run_ctrl;

    logic        CLK = 1'b0;
    logic        start = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [7:0]  ld_addr = 8'd0;
    logic [7:0]  ld_data = 8'd0;
    logic        go = 1'b0;
    logic        dut_halt = 1'b0;
    logic        dut_start;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    run_ctrl #(.RESET_CYCLES(2), .TIMEOUT(16'd20)) dut (
        .CLK(CLK), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .go(go), .dut_halt(dut_halt),
        .dut_start(dut_start), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // From IDLE/DONE: pulse go and advance to the first RUN cycle.
    task automatic launch();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(2);
    endtask

    logic [7:0] pre_data [3];

    initial begin
        pre_data[0] = 8'hA5;
        pre_data[1] = 8'h5A;
        pre_data[2] = 8'hFF;

        // Reset
        tick();
        chk("rst_ld_ready_held", 32'(ld_ready), 32'd0);
        start = 1'b0;
        #1;
        chk("rst_dut_start", 32'(dut_start), 32'd1);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);
        chk("idle_ld_ready", 32'(ld_ready), 32'd1);

        // Preload: three back-to-back writes
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 8'(i);
            ld_data  = pre_data[i];
            tick();
            chk("pre_wr_en", 32'(mem_wr_en), 32'd1);
            chk("pre_addr", 32'(mem_addr), 32'(i));
            chk("pre_data", 32'(mem_data), 32'(pre_data[i]));
        end
        ld_valid = 1'b0;
        tick();
        chk("pre_wr_end", 32'(mem_wr_en), 32'd0);

        // Normal run, halt in RUN cycle 10; halt in cycle 1 ignored
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("rd_dut_start1", 32'(dut_start), 32'd1);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        chk("rd_dut_start2", 32'(dut_start), 32'd1);
        tick();
        chk("run_dut_start", 32'(dut_start), 32'd0);
        chk("run_count0", 32'(cycle_count), 32'd0);
        dut_halt = 1'b1;
        tick();
        dut_halt = 1'b0;
        chk("halt_c1_ignored_done", 32'(done), 32'd0);
        chk("halt_c1_ignored_busy", 32'(busy), 32'd1);
        chk("run_count1", 32'(cycle_count), 32'd1);
        go = 1'b1;
        tick(8);
        go = 1'b0;
        chk("run_count9", 32'(cycle_count), 32'd9);
        dut_halt = 1'b1;
        tick();
        dut_halt = 1'b0;
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_timeout", 32'(timeout), 32'd0);
        chk("halt_count", 32'(cycle_count), 32'd10);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_dut_start", 32'(dut_start), 32'd0);
        tick();
        chk("done_hold", 32'(done), 32'd1);
        chk("done_count_frozen", 32'(cycle_count), 32'd10);

        // Rerun from DONE, ends on the limit
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("rerun_count_clr", 32'(cycle_count), 32'd0);
        chk("rerun_done_clr", 32'(done), 32'd0);
        tick(2);
        tick(19);
        chk("to_pre_done", 32'(done), 32'd0);
        chk("to_pre_count", 32'(cycle_count), 32'd19);
        tick();
        chk("to_done", 32'(done), 32'd1);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_count", 32'(cycle_count), 32'd20);

        // Reset coinciding with a load request in DONE
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 8'h30;
        ld_data  = 8'h99;
        #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        chk("rstld_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rstld_done", 32'(done), 32'd0);
        chk("rstld_timeout", 32'(timeout), 32'd0);
        chk("rstld_count", 32'(cycle_count), 32'd0);
        chk("rstld_dut_start", 32'(dut_start), 32'd1);
        tick();
        chk("rstld_wr_en2", 32'(mem_wr_en), 32'd0);

        // Halt on the limit cycle
        launch();
        tick(19);
        dut_halt = 1'b1;
        tick();
        dut_halt = 1'b0;
        chk("hl_done", 32'(done), 32'd1);
        chk("hl_timeout", 32'(timeout), 32'd0);
        chk("hl_count", 32'(cycle_count), 32'd20);

        // Load in DONE returns to IDLE, keeps count
        ld_valid = 1'b1;
        ld_addr  = 8'h10;
        ld_data  = 8'h3C;
        tick();
        ld_valid = 1'b0;
        chk("dl_wr_en", 32'(mem_wr_en), 32'd1);
        chk("dl_addr", 32'(mem_addr), 32'h10);
        chk("dl_done", 32'(done), 32'd0);
        chk("dl_count", 32'(cycle_count), 32'd20);
        chk("dl_dut_start", 32'(dut_start), 32'd1);

        // Collision in IDLE: load wins, go dropped
        go       = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 8'h21;
        ld_data  = 8'h88;
        tick();
        go       = 1'b0;
        ld_valid = 1'b0;
        chk("col_wr_en", 32'(mem_wr_en), 32'd1);
        chk("col_data", 32'(mem_data), 32'h88);
        chk("col_busy", 32'(busy), 32'd0);
        tick();
        chk("col_not_latched", 32'(busy), 32'd0);
        chk("col_wr_end", 32'(mem_wr_en), 32'd0);

        // Reset mid-RUN at cycle 5
        launch();
        tick(4);
        chk("mr_count4", 32'(cycle_count), 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mr_dut_start", 32'(dut_start), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_count", 32'(cycle_count), 32'd0);
        chk("mr_wr_en", 32'(mem_wr_en), 32'd0);
        tick();
        chk("mr_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
